fdtd_wt_arbiter: RTL and testbench

Shares one single-word AXI write engine among `NUM_REQ` FDTD write requesters. The block selects one pending requester, either round-robin or fixed-priority. It latches that requester's word address and data and drives the engine's request/address/data inputs. When the engine completes the write, it returns a one-cycle grant to the winning requester. It sits between the FDTD update datapath and the word-write AXI master, and removes the engine's duplicate-write hazard (its request is sampled one cycle late) by dropping the engine request as soon as the AW handshake is observed.

---
 rtl/fdtd_wt_arbiter_if.sv | 41 ++++
 rtl/fdtd_wt_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fdtd_wt_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdtd_wt_arbiter_if.sv
// -----------------------------------------------------------------------------
// fdtd_wt_arbiter_if
//   Bundles the requester-side and engine-side signals of the FDTD write
//   arbiter.
//
//   Requester side : req_i, word_addr_i, data_i (packed, slice k = requester k),
//                    gnt_o (one-hot completion pulse)
//   Engine side    : wt_req_o, wt_word_addr_o, wt_data_o (towards the engine),
//                    wt_gnt_i (B response accepted), aw_fire_i (AW handshake)
//
//   modport master : used by the arbiter (it masters the shared write engine)
//   modport slave  : used by the surrounding requesters/engine (or a bench)
// -----------------------------------------------------------------------------
interface fdtd_wt_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32
);
  localparam int WA = AXI4_ADDR_WIDTH - 2;

  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ*WA-1:0]              word_addr_i;
  logic [NUM_REQ*AXI4_DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]                 gnt_o;

  logic                               wt_req_o;
  logic [WA-1:0]                      wt_word_addr_o;
  logic [AXI4_DATA_WIDTH-1:0]         wt_data_o;
  logic                               wt_gnt_i;
  logic                               aw_fire_i;

  modport master (
    input  req_i, word_addr_i, data_i, wt_gnt_i, aw_fire_i,
    output gnt_o, wt_req_o, wt_word_addr_o, wt_data_o
  );

  modport slave (
    output req_i, word_addr_i, data_i, wt_gnt_i, aw_fire_i,
    input  gnt_o, wt_req_o, wt_word_addr_o, wt_data_o
  );
endinterface

// File: rtl/fdtd_wt_arbiter.sv
// -----------------------------------------------------------------------------
// fdtd_wt_arbiter
//   Shares one single-word AXI write engine among NUM_REQ FDTD write
//   requesters. One pending requester is selected, its word address and data
//   are latched and presented to the engine, and a one-cycle one-hot grant is
//   returned once the engine reports completion.
//
//   The engine samples its request one cycle late, so the request is dropped
//   as soon as the AW handshake is seen; this prevents a duplicate write.
//
//   Ports
//     ACLK      : clock, rising edge
//     ARESET    : asynchronous active-high reset
//     bus       : fdtd_wt_arbiter_if.master (requester and engine signals)
//     busy_o    : high whenever the arbiter is not idle
//     cur_id_o  : index of the requester being served (valid while busy_o)
//
//   Configuration macro
//     FDTD_WT_ARB_RR_EN : defined   -> round-robin with rotating pointer
//                         undefined -> fixed priority, lowest index wins
//   In both modes the requester just granted is masked for one idle cycle so
//   it may drop its request one cycle after the grant.
// -----------------------------------------------------------------------------
module fdtd_wt_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  fdtd_wt_arbiter_if.master           bus,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  cur_id_o
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WA   = AXI4_ADDR_WIDTH - 2;
  localparam int DW   = AXI4_DATA_WIDTH;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

  state_t               state_reg;
  logic [ID_W-1:0]      sel_reg;
  logic [NUM_REQ-1:0]   mask_reg;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic                 wt_req_reg;
  logic                 busy_reg;
  logic [WA-1:0]        addr_reg;
  logic [DW-1:0]        data_reg;
`ifdef FDTD_WT_ARB_RR_EN
  logic [ID_W-1:0]      ptr_reg;
`endif

  logic [WA-1:0]        addr_arr [NUM_REQ];
  logic [DW-1:0]        data_arr [NUM_REQ];
  // cand_id[i] is the requester examined at search position i
  logic [ID_W-1:0]      cand_id  [NUM_REQ];
  logic [NUM_REQ-1:0]   elig;
  logic                 pick_valid;
  logic [ID_W-1:0]      pick_id;

  // The post-grant mask is only non-zero in the idle cycle right after ACK.
  assign elig = bus.req_i & ~mask_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi] = bus.word_addr_i[gi*WA +: WA];
    assign data_arr[gi] = bus.data_i[gi*DW +: DW];
`ifdef FDTD_WT_ARB_RR_EN
    // Search position gi maps to (ptr + gi) mod NUM_REQ; one extra bit keeps
    // the sum from wrapping before the explicit modulo subtract.
    logic [ID_W:0] rot_sum;
    assign rot_sum      = {1'b0, ptr_reg} + (ID_W+1)'(gi);
    assign cand_id[gi]  = (rot_sum >= (ID_W+1)'(NUM_REQ))
                          ? ID_W'(rot_sum - (ID_W+1)'(NUM_REQ))
                          : rot_sum[ID_W-1:0];
`else
    assign cand_id[gi]  = ID_W'(gi);
`endif
  end

  // Scan from the last search position down to the first so that the
  // earliest eligible position wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[cand_id[i]]) begin
        pick_valid = 1'b1;
        pick_id    = cand_id[i];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      mask_reg   <= '0;
      gnt_reg    <= '0;
      wt_req_reg <= 1'b0;
      busy_reg   <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
`ifdef FDTD_WT_ARB_RR_EN
      ptr_reg    <= '0;
`endif
    end else begin
      gnt_reg  <= '0;
      mask_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            sel_reg    <= pick_id;
            addr_reg   <= addr_arr[pick_id];
            data_reg   <= data_arr[pick_id];
            wt_req_reg <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          // Completion can beat (or coincide with) the AW handshake when the
          // engine collapses its phases; go straight to ACK in that case.
          if (bus.wt_gnt_i) begin
            wt_req_reg <= 1'b0;
            gnt_reg    <= ONE_HOT0 << sel_reg;
            state_reg  <= ACK;
          end else if (bus.aw_fire_i) begin
            wt_req_reg <= 1'b0;
            state_reg  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Address/data stay latched: the engine drives WDATA from them.
          if (bus.wt_gnt_i) begin
            gnt_reg   <= ONE_HOT0 << sel_reg;
            state_reg <= ACK;
          end
        end
        ACK: begin
          mask_reg  <= ONE_HOT0 << sel_reg;
          busy_reg  <= 1'b0;
`ifdef FDTD_WT_ARB_RR_EN
          ptr_reg   <= (sel_reg == ID_W'(NUM_REQ - 1)) ? '0 : sel_reg + 1'b1;
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o          = gnt_reg;
  assign bus.wt_req_o       = wt_req_reg;
  assign bus.wt_word_addr_o = addr_reg;
  assign bus.wt_data_o      = data_reg;
  assign busy_o             = busy_reg;
  assign cur_id_o           = sel_reg;

endmodule

// File: tb/tb_fdtd_wt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fdtd_wt_arbiter
//   Directed bench for fdtd_wt_arbiter with a transaction-level reference
//   model (who owns the engine, whether its request is still outstanding,
//   whether the completion grant is showing) checked on every falling edge,
//   plus hand-computed literal expectations per scenario.
// -----------------------------------------------------------------------------
module tb_fdtd_wt_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WA = AW - 2;

  logic       ACLK;
  logic       ARESET;
  logic       busy_o;
  logic [1:0] cur_id_o;

  fdtd_wt_arbiter_if #(.NUM_REQ(N), .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW)) bus ();

  fdtd_wt_arbiter #(.NUM_REQ(N), .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus),
    .busy_o   (busy_o),
    .cur_id_o (cur_id_o)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_gnt_pulses = 0;
  int n_req_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_busy, m_req, m_ack, m_owner, m_last, m_ptr;
  logic [WA-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic m_reset();
    m_busy = 0; m_req = 0; m_ack = 0; m_owner = 0;
    m_last = -1; m_ptr = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic m_step();
    int pick;
    if (m_ack != 0) begin
      // grant was visible this cycle: transaction retires
      m_ack  = 0;
      m_busy = 0;
      m_last = m_owner;
`ifdef FDTD_WT_ARB_RR_EN
      m_ptr  = (m_owner + 1) % N;
`endif
    end else if (m_busy == 0) begin
      pick = -1;
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_ptr + off) % N;
        if (pick < 0 && bus.req_i[idx] && idx != m_last) pick = idx;
      end
      m_last = -1;
      if (pick >= 0) begin
        m_busy  = 1;
        m_req   = 1;
        m_owner = pick;
        m_addr  = bus.word_addr_i[pick*WA +: WA];
        m_data  = bus.data_i[pick*DW +: DW];
      end
    end else begin
      if (bus.wt_gnt_i) begin
        m_ack = 1;
        m_req = 0;
      end else if (bus.aw_fire_i && m_req != 0) begin
        m_req = 0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge ACLK or posedge ARESET);
      if (ARESET) m_reset();
      else        m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge ACLK);
      chk("gnt_o",  bus.gnt_o, (m_ack != 0) ? (64'd1 << m_owner) : 64'd0);
      chk("wt_req", bus.wt_req_o, (m_req != 0) ? 64'd1 : 64'd0);
      chk("busy",   busy_o, (m_busy != 0) ? 64'd1 : 64'd0);
      chk("addr",   bus.wt_word_addr_o, m_addr);
      chk("data",   bus.wt_data_o, m_data);
      if (m_busy != 0) chk("cur_id", cur_id_o, m_owner);
      if (bus.gnt_o != '0) n_gnt_pulses++;
      if (bus.wt_req_o) n_req_cycles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_wt_req(output int lat);
    lat = 0;
    while (bus.wt_req_o !== 1'b1 && lat < 50) begin
      @(negedge ACLK);
      lat++;
    end
    if (bus.wt_req_o !== 1'b1) chk("wt_req_timeout", bus.wt_req_o, 1);
  endtask

  // Acts as the write engine for one transaction; returns the granted index.
  task automatic do_txn(input int aw_delay, input int b_delay, input bit collapse, output int gid);
    int lat;
    wait_wt_req(lat);
    repeat (aw_delay) @(negedge ACLK);
    bus.aw_fire_i = 1'b1;
    if (collapse) bus.wt_gnt_i = 1'b1;
    @(negedge ACLK);
    bus.aw_fire_i = 1'b0;
    bus.wt_gnt_i  = 1'b0;
    if (!collapse) begin
      repeat (b_delay) @(negedge ACLK);
      bus.wt_gnt_i = 1'b1;
      @(negedge ACLK);
      bus.wt_gnt_i = 1'b0;
    end
    gid = -1;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt_o != '0) begin
        chk("gnt_onehot", $countones(bus.gnt_o), 1);
        for (int k = 0; k < N; k++) if (bus.gnt_o[k]) gid = k;
        break;
      end
      @(negedge ACLK);
    end
  endtask

  task automatic set_slot(input int k, input logic [WA-1:0] a, input logic [DW-1:0] d);
    bus.word_addr_i[k*WA +: WA] = a;
    bus.data_i[k*DW +: DW]      = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int gid, lat, snap;
    int exp_order[5];
`ifdef FDTD_WT_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 1, 0, 1, 0};
`endif
    ARESET        = 1'b1;
    bus.req_i     = '0;
    bus.aw_fire_i = 1'b0;
    bus.wt_gnt_i  = 1'b0;
    for (int k = 0; k < N; k++) set_slot(k, WA'(32'h200 + k), 32'hA0A0_0000 | k);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("reset_busy", busy_o, 0);
    chk("reset_wt_req", bus.wt_req_o, 0);
    chk("reset_gnt", bus.gnt_o, 0);
    chk("reset_data", bus.wt_data_o, 0);

    // All four requesting continuously
    bus.req_i = 4'hF;
    for (int t = 0; t < 5; t++) begin
      do_txn(t % 2, 1, 1'b0, gid);
      $display("txn continuous #%0d: granted %0d", t, gid);
      chk("order", gid, exp_order[t]);
    end
    bus.req_i = '0;
    repeat (3) @(negedge ACLK);

    // Single request, requester 1
    set_slot(1, 30'h100, 32'hDEADBEEF);
    snap = n_gnt_pulses;
    bus.req_i = 4'b0010;
    wait_wt_req(lat);
    chk("single_latency", lat, 1);
    chk("single_addr", bus.wt_word_addr_o, 30'h100);
    chk("single_data", bus.wt_data_o, 32'hDEADBEEF);
    chk("single_cur_id", cur_id_o, 1);
    do_txn(1, 2, 1'b0, gid);
    chk("single_gnt_vec", bus.gnt_o, 4'b0010);
    bus.req_i = '0;
    $display("txn single: granted %0d", gid);
    chk("single_gid", gid, 1);
    repeat (3) @(negedge ACLK);
    chk("single_pulses", n_gnt_pulses - snap, 1);

    // AWREADY stalled 5 cycles, requester 2
    set_slot(2, 30'h3FF0, 32'h1234_5678);
    n_req_cycles = 0;
    bus.req_i = 4'b0100;
    do_txn(5, 2, 1'b0, gid);
    bus.req_i = '0;
    $display("txn stall: granted %0d", gid);
    chk("stall_gid", gid, 2);
    repeat (2) @(negedge ACLK);
    chk("stall_req_cycles", n_req_cycles, 6);

    // Reset pulsed in WAIT_DONE
    snap = n_gnt_pulses;
    bus.req_i = 4'b0100;
    wait_wt_req(lat);
    bus.aw_fire_i = 1'b1;
    @(negedge ACLK);
    bus.aw_fire_i = 1'b0;
    @(negedge ACLK);
    #2;
    ARESET = 1'b1;
    bus.req_i = '0;
    @(negedge ACLK);
    chk("rst_wt_req", bus.wt_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", bus.wt_word_addr_o, 0);
    chk("rst_data", bus.wt_data_o, 0);
    chk("rst_gnt", bus.gnt_o, 0);
    ARESET = 1'b0;
    repeat (4) @(negedge ACLK);
    chk("rst_no_gnt", n_gnt_pulses - snap, 0);
    $display("txn reset-abort: grants emitted %0d", n_gnt_pulses - snap);
    set_slot(3, 30'h0ABC, 32'hCAFE_F00D);
    bus.req_i = 4'b1000;
    do_txn(0, 1, 1'b0, gid);
    bus.req_i = '0;
    $display("txn after reset: granted %0d", gid);
    chk("post_rst_gid", gid, 3);
    repeat (3) @(negedge ACLK);

    // Completion arriving while still in ISSUE
    snap = n_gnt_pulses;
    bus.req_i = 4'b0001;
    do_txn(2, 0, 1'b1, gid);
    bus.req_i = '0;
    $display("txn collapsed: granted %0d", gid);
    chk("collapse_gid", gid, 0);
    repeat (3) @(negedge ACLK);
    chk("collapse_pulses", n_gnt_pulses - snap, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
